// File: rtl/seven_seg_scanner_pkg.sv
// Shared display parameters: default geometry, special digit codes and
// active-low segment patterns (bit 6 = a ... bit 0 = g).
package seven_seg_scanner_pkg;

    localparam int DEFAULT_DIGITS   = 4;
    localparam int DEFAULT_CLK_HZ   = 100_000_000;
    localparam int DEFAULT_DIGIT_HZ = 1000;
    localparam int DEFAULT_BRIGHT_W = 3;

    typedef logic [6:0] seg_t;

    // Digit codes shared with the BCD producer.
    localparam logic [3:0] CODE_MINUS = 4'hF;
    localparam logic [3:0] CODE_BLANK = 4'hA;

    localparam seg_t SEG_BLANK = 7'b1111111;
    localparam seg_t SEG_MINUS = 7'b1111110;
    localparam seg_t SEG_ERROR = 7'b0110110;

    localparam seg_t SEG_DIGIT [10] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
        7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100
    };

endpackage

// File: rtl/seven_seg_scanner_if.sv
// Panel bus between the BCD producer (master) and the scanner (slave).
interface seven_seg_scanner_if
    import seven_seg_scanner_pkg::*;
#(
    parameter int DIGITS   = DEFAULT_DIGITS,
    parameter int BRIGHT_W = DEFAULT_BRIGHT_W
);
    logic [DIGITS*4-1:0]  digits_i;
    logic [DIGITS-1:0]    dp_i;
    logic                 blank_lz_i;
    logic [BRIGHT_W-1:0]  bright_i;
    logic                 en_i;
    seg_t                 led_7seg_o;
    logic                 dp_o;
    logic [DIGITS-1:0]    anode_o;
    logic                 frame_o;

    modport master (
        output digits_i, dp_i, blank_lz_i, bright_i, en_i,
        input  led_7seg_o, dp_o, anode_o, frame_o
    );

    modport slave (
        input  digits_i, dp_i, blank_lz_i, bright_i, en_i,
        output led_7seg_o, dp_o, anode_o, frame_o
    );
endinterface

// File: rtl/seven_seg_scanner_seg7_decoder.sv
// Combinational 4-bit code to active-low seven-segment pattern.
// Codes B..E have no glyph and show the error pattern.
module seg7_decoder
    import seven_seg_scanner_pkg::*;
(
    input  logic [3:0] code,
    input  logic       blank,
    output seg_t       seg
);
    // Decode with blanking taking priority over the code.
    // NOTE: seg gets a default first so every path assigns it and no latch is inferred.
    always_comb begin
        seg = SEG_ERROR;
        if (blank || code == CODE_BLANK) begin
            seg = SEG_BLANK;
        end else if (code == CODE_MINUS) begin
            seg = SEG_MINUS;
        end else if (code <= 4'd9) begin
            seg = SEG_DIGIT[code];
        end
    end
endmodule

// File: rtl/seven_seg_scanner.sv
// Multiplexed common-anode seven-segment scanner with per-digit points,
// leading-zero blanking, PWM brightness, one dead-time cycle per slot and
// frame-coherent input sampling. The bus interface must be built with the
// same DIGITS/BRIGHT_W as this module.
module seven_seg_scanner
    import seven_seg_scanner_pkg::*;
#(
    parameter int DIGITS   = DEFAULT_DIGITS,
    parameter int CLK_HZ   = DEFAULT_CLK_HZ,
    parameter int DIGIT_HZ = DEFAULT_DIGIT_HZ,
    parameter int BRIGHT_W = DEFAULT_BRIGHT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    seven_seg_scanner_if.slave   bus
);
    localparam int TICK_DIV = CLK_HZ / DIGIT_HZ;
    localparam int SUB      = TICK_DIV / (2 ** BRIGHT_W);
    localparam int DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SUB_W    = (SUB > 1) ? $clog2(SUB) : 1;
    localparam int IDX_W    = $clog2(DIGITS);

    logic [DIV_W-1:0]    div_cnt;
    logic [SUB_W-1:0]    sub_cnt;
    logic [BRIGHT_W-1:0] phase;
    logic [IDX_W-1:0]    idx;
    logic                slot_start;
    logic                slot_end;
    logic                frame_start;

    logic [DIGITS*4-1:0] sh_digits;
    logic [DIGITS-1:0]   sh_dp;
    logic                sh_blank_lz;
    logic [BRIGHT_W-1:0] sh_bright;

    // Values the current cycle displays: on frame start the fresh inputs,
    // so the dead-time cycle already carries the new frame's data.
    logic [DIGITS*4-1:0] eff_digits;
    logic [DIGITS-1:0]   eff_dp;
    logic                eff_blank_lz;

    logic [DIGITS-1:0]   blank_mask;
    logic                zero_run;
    logic [3:0]          cur_code;
    seg_t                cur_seg;
    logic                lit;

    assign slot_start  = (div_cnt == '0);
    assign slot_end    = (div_cnt == DIV_W'(TICK_DIV - 1));
    assign frame_start = slot_start && (idx == '0);

    assign eff_digits   = frame_start ? bus.digits_i   : sh_digits;
    assign eff_dp       = frame_start ? bus.dp_i       : sh_dp;
    assign eff_blank_lz = frame_start ? bus.blank_lz_i : sh_blank_lz;

    // Slot divider, PWM phase counter and scan index.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
            sub_cnt <= '0;
            phase   <= '0;
            idx     <= '0;
        end else if (slot_end) begin
            div_cnt <= '0;
            sub_cnt <= '0;
            phase   <= '0;
            idx     <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + 1'b1;
        end else begin
            div_cnt <= div_cnt + 1'b1;
            if (sub_cnt == SUB_W'(SUB - 1)) begin
                sub_cnt <= '0;
                phase   <= phase + 1'b1;
            end else begin
                sub_cnt <= sub_cnt + 1'b1;
            end
        end
    end

    // Shadow registers reload only at frame start so a frame never mixes old and new data.
    // NOTE: the shadows are cleared on reset so the first frame never shows undefined data.
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_digits   <= '0;
            sh_dp       <= '0;
            sh_blank_lz <= 1'b0;
            sh_bright   <= '0;
        end else if (frame_start) begin
            sh_digits   <= bus.digits_i;
            sh_dp       <= bus.dp_i;
            sh_blank_lz <= bus.blank_lz_i;
            sh_bright   <= bus.bright_i;
        end
    end

    // Leading-zero mask: walk from the leftmost digit while digits stay zero; digit 0 always shows.
    always_comb begin
        blank_mask = '0;
        zero_run   = eff_blank_lz;
        for (int i = DIGITS - 1; i > 0; i--) begin
            zero_run      = zero_run && (eff_digits[4*i +: 4] == 4'd0);
            blank_mask[i] = zero_run;
        end
    end

    assign cur_code = eff_digits[{idx, 2'b00} +: 4];

    seg7_decoder u_decoder (
        .code  (cur_code),
        .blank (blank_mask[idx]),
        .seg   (cur_seg)
    );

    // Anode is lit outside the dead-time cycle while the PWM phase is within the brightness setting.
    assign lit = bus.en_i && !slot_start && (phase <= sh_bright);

    // Output registers; reset darkens the panel at the very next edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.anode_o    <= '1;
            bus.led_7seg_o <= SEG_BLANK;
            bus.dp_o       <= 1'b1;
            bus.frame_o    <= 1'b0;
        end else begin
            bus.anode_o    <= lit ? ~(DIGITS'(1) << idx) : '1;
            bus.led_7seg_o <= cur_seg;
            bus.dp_o       <= ~eff_dp[idx];
            bus.frame_o    <= frame_start;
        end
    end
endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner with DIGITS=4, TICK_DIV=16, SUB=2.
// Slot-relative cycle numbers below count from the cycle in which frame_o is seen high.
module tb_seven_seg_scanner;

    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;

    seven_seg_scanner_if #(.DIGITS(4), .BRIGHT_W(3)) bus ();

    seven_seg_scanner #(
        .DIGITS   (4),
        .CLK_HZ   (1600),
        .DIGIT_HZ (100),
        .BRIGHT_W (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Advance to the next cycle with frame_o high; n returns the cycles taken.
    task automatic wait_frame(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (bus.frame_o !== 1'b1 && n < 200);
        if (bus.frame_o !== 1'b1) begin
            tests_run++;
            tests_failed++;
            $display("FAIL wait_frame: no frame_o within %0d cycles", n);
        end
    endtask

    // Walk one full frame starting at its frame_o cycle.
    task automatic scan_frame(input string name, input logic [27:0] exp_seg,
                              input logic [3:0] exp_dp, input int lit_last);
        logic [3:0] exp_an;
        int lit;
        for (int s = 0; s < 4; s++) begin
            lit = 0;
            for (int j = 0; j < 16; j++) begin
                exp_an = (j >= 1 && j <= lit_last) ? ~(4'b0001 << s) : 4'b1111;
                tests_run++;
                if (bus.anode_o !== exp_an) begin
                    tests_failed++;
                    $display("FAIL %s anode slot%0d cyc%0d: got %b want %b", name, s, j, bus.anode_o, exp_an);
                end
                tests_run++;
                if (bus.led_7seg_o !== exp_seg[7*s +: 7]) begin
                    tests_failed++;
                    $display("FAIL %s seg slot%0d cyc%0d: got %b want %b", name, s, j, bus.led_7seg_o, exp_seg[7*s +: 7]);
                end
                tests_run++;
                if (bus.dp_o !== exp_dp[s]) begin
                    tests_failed++;
                    $display("FAIL %s dp slot%0d cyc%0d: got %b want %b", name, s, j, bus.dp_o, exp_dp[s]);
                end
                tests_run++;
                if (bus.frame_o !== (s == 0 && j == 0)) begin
                    tests_failed++;
                    $display("FAIL %s frame slot%0d cyc%0d: got %b want %b", name, s, j, bus.frame_o, (s == 0 && j == 0));
                end
                if (bus.anode_o !== 4'b1111) lit++;
                step();
            end
            tests_run++;
            if (lit != lit_last) begin
                tests_failed++;
                $display("FAIL %s lit count slot%0d: got %0d want %0d", name, s, lit, lit_last);
            end
        end
    endtask

    task automatic test_reset();
        rst            = 1'b1;
        bus.digits_i   = 16'h1234;
        bus.dp_i       = 4'b0000;
        bus.blank_lz_i = 1'b0;
        bus.bright_i   = 3'd7;
        bus.en_i       = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            tests_run++;
            if (bus.anode_o !== 4'b1111 || bus.led_7seg_o !== 7'b1111111 ||
                bus.dp_o !== 1'b1 || bus.frame_o !== 1'b0) begin
                tests_failed++;
                $display("FAIL reset hold cyc%0d: got an=%b seg=%b dp=%b fr=%b want 1111/1111111/1/0",
                         k, bus.anode_o, bus.led_7seg_o, bus.dp_o, bus.frame_o);
            end
        end
        rst = 1'b0;
        step();
        tests_run++;
        if (bus.frame_o !== 1'b1 || bus.anode_o !== 4'b1111) begin
            tests_failed++;
            $display("FAIL reset release first: got fr=%b an=%b want 1/1111", bus.frame_o, bus.anode_o);
        end
        step();
        tests_run++;
        if (bus.anode_o !== 4'b1110 || bus.frame_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset release second: got an=%b fr=%b want 1110/0", bus.anode_o, bus.frame_o);
        end
    endtask

    task automatic test_full_bright();
        int n;
        wait_frame(n);
        wait_frame(n);
        tests_run++;
        if (n != 64) begin
            tests_failed++;
            $display("FAIL frame period: got %0d want 64", n);
        end
        scan_frame("full", {7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100}, 4'b1111, 15);
    endtask

    task automatic test_zero_blank();
        int n;
        bus.digits_i   = 16'h0050;
        bus.blank_lz_i = 1'b1;
        bus.dp_i       = 4'b0010;
        wait_frame(n);
        scan_frame("zblank", {7'b1111111, 7'b1111111, 7'b0100100, 7'b0000001}, 4'b1101, 15);
    endtask

    task automatic test_pwm();
        int n;
        bus.bright_i = 3'd1;
        wait_frame(n);
        scan_frame("pwm", {7'b1111111, 7'b1111111, 7'b0100100, 7'b0000001}, 4'b1101, 3);
    endtask

    task automatic test_frame_coherence();
        int n;
        logic [6:0] exp_seg;
        bus.digits_i   = 16'h1234;
        bus.blank_lz_i = 1'b0;
        bus.dp_i       = 4'b0000;
        bus.bright_i   = 3'd7;
        wait_frame(n);
        for (int k = 0; k < 32; k++) step();
        bus.digits_i = 16'h9999;
        for (int k = 0; k < 32; k++) begin
            exp_seg = (k < 16) ? 7'b0010010 : 7'b1001111;
            tests_run++;
            if (bus.led_7seg_o !== exp_seg || bus.frame_o !== 1'b0) begin
                tests_failed++;
                $display("FAIL coherence old k%0d: got seg=%b fr=%b want %b/0", k, bus.led_7seg_o, bus.frame_o, exp_seg);
            end
            step();
        end
        scan_frame("coherent", {4{7'b0000100}}, 4'b1111, 15);
    endtask

    task automatic test_enable_codes();
        int n;
        int dark;
        bus.digits_i = 16'hFAC8;
        wait_frame(n);
        scan_frame("codes", {7'b1111110, 7'b1111111, 7'b0110110, 7'b0000000}, 4'b1111, 15);
        for (int k = 0; k < 5; k++) step();
        tests_run++;
        if (bus.anode_o !== 4'b1110) begin
            tests_failed++;
            $display("FAIL enable before drop: got %b want 1110", bus.anode_o);
        end
        bus.en_i = 1'b0;
        step();
        tests_run++;
        if (bus.anode_o !== 4'b1111) begin
            tests_failed++;
            $display("FAIL enable drop: got %b want 1111", bus.anode_o);
        end
        wait_frame(n);
        tests_run++;
        if (n != 58) begin
            tests_failed++;
            $display("FAIL enable frame continues: got %0d cycles want 58", n);
        end
        dark = 0;
        for (int k = 0; k < 20; k++) begin
            if (bus.anode_o === 4'b1111) dark++;
            step();
        end
        tests_run++;
        if (dark != 20) begin
            tests_failed++;
            $display("FAIL enable dark cycles: got %0d want 20", dark);
        end
        bus.en_i = 1'b1;
        step();
        tests_run++;
        if (bus.anode_o !== 4'b1101) begin
            tests_failed++;
            $display("FAIL enable restore: got %b want 1101", bus.anode_o);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        wait_frame(n);
        for (int k = 0; k < 4; k++) step();
        rst = 1'b1;
        step();
        tests_run++;
        if (bus.anode_o !== 4'b1111 || bus.led_7seg_o !== 7'b1111111 ||
            bus.dp_o !== 1'b1 || bus.frame_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset mid: got an=%b seg=%b dp=%b fr=%b want 1111/1111111/1/0",
                     bus.anode_o, bus.led_7seg_o, bus.dp_o, bus.frame_o);
        end
        rst = 1'b0;
        step();
        tests_run++;
        if (bus.frame_o !== 1'b1 || bus.led_7seg_o !== 7'b0000000) begin
            tests_failed++;
            $display("FAIL reset mid restart: got fr=%b seg=%b want 1/0000000", bus.frame_o, bus.led_7seg_o);
        end
        step();
        tests_run++;
        if (bus.anode_o !== 4'b1110) begin
            tests_failed++;
            $display("FAIL reset mid lit: got %b want 1110", bus.anode_o);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_full_bright();
        test_zero_blank();
        test_pwm();
        test_frame_coherence();
        test_enable_codes();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
